// File: rtl/fire_pkg.sv
// Shared spike-tag types for the neuron pipeline, fire FIFO and fan-out stage.
package fire_pkg;

  localparam int TAG_W = 8;

  typedef logic [TAG_W-1:0] tag_t;

  // Occupancy needs one more bit than the pointer so DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fire_fifo_mem.sv
// Tag storage for the fire FIFO: one synchronous write port, one async read port.
module fire_fifo_mem #(
  parameter int TAG_W = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [TAG_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [TAG_W-1:0] rdata
);

  logic [TAG_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fire_tag_fifo.sv
// Spike-tag FIFO between neuron update and synapse fan-out, with drop accounting.
module fire_tag_fifo
  import fire_pkg::*;
#(
  parameter int TAG_W     = fire_pkg::TAG_W,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int DROP_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq,
  input  logic                     deq,
  input  logic                     flush,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [TAG_W-1:0] rdata;
  logic             enq_acc;
  logic             deq_acc;
  logic             drop;
  logic             we;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign enq_acc = enq && (!full || deq);
  assign deq_acc = deq && !empty;
  assign drop    = enq && full && !deq;
  assign we      = enq_acc && reset_n && !flush;

  fire_fifo_mem #(
    .TAG_W (TAG_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (in_tag),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (enq_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(enq_acc) - CW'(deq_acc);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
      if (deq && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CW'(AFULL_LVL));
  assign out_tag     = empty ? '0 : rdata;

endmodule

// File: tb/tb_fire_tag_fifo.sv
// Random + directed scoreboard bench for fire_tag_fifo against a queue model.
module tb_fire_tag_fifo;

  localparam int TAG_W  = 8;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;
  localparam int DROP_W = 3;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             enq;
  logic             deq;
  logic             flush;
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [2:0]       count;
  logic             overflow;
  logic             underflow;
  logic [DROP_W-1:0] drop_cnt;

  fire_tag_fifo #(
    .TAG_W     (TAG_W),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL),
    .DROP_W    (DROP_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enq         (enq),
    .deq         (deq),
    .flush       (flush),
    .in_tag      (in_tag),
    .out_tag     (out_tag),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int cnt;
    int full;
    int empty;
    int af;
    int ovf;
    int unf;
    int drops;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];
  int   m_ovf;
  int   m_unf;
  int   m_drops;
  int   checks;
  int   errors;
  int   cyc;

  task automatic chk(input string name, input int got, input int want,
                     input int at);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, at, got, want);
    end
  endtask

  // Reference behaviour: a plain queue with the accept rules applied to
  // the state seen before the edge.
  task automatic model(input bit r, input bit f, input bit e, input bit d,
                       input int tag);
    bit was_full;
    bit was_empty;
    if (!r || f) begin
      mq.delete();
      m_ovf   = 0;
      m_unf   = 0;
      m_drops = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (d && !was_empty) void'(mq.pop_front());
      if (e) begin
        if (!was_full || d) begin
          mq.push_back(tag);
        end else begin
          m_ovf = 1;
          if (m_drops < DMAX) m_drops++;
        end
      end
      if (d && was_empty) m_unf = 1;
    end
  endtask

  task automatic step(input bit r, input bit f, input bit e, input bit d,
                      input int tag);
    exp_t x;
    reset_n = r;
    flush   = f;
    enq     = e;
    deq     = d;
    in_tag  = tag[TAG_W-1:0];
    model(r, f, e, d, tag);
    @(posedge clk);
    cyc++;
    x.tag   = (mq.size() != 0) ? mq[0] : 0;
    x.cnt   = mq.size();
    x.full  = (mq.size() == DEPTH) ? 1 : 0;
    x.empty = (mq.size() == 0) ? 1 : 0;
    x.af    = (mq.size() >= AFULL) ? 1 : 0;
    x.ovf   = m_ovf;
    x.unf   = m_unf;
    x.drops = m_drops;
    x.cyc   = cyc;
    exp_q.push_back(x);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk("out_tag",     int'(out_tag),     x.tag,   x.cyc);
      chk("count",       int'(count),       x.cnt,   x.cyc);
      chk("full",        int'(full),        x.full,  x.cyc);
      chk("empty",       int'(empty),       x.empty, x.cyc);
      chk("almost_full", int'(almost_full), x.af,    x.cyc);
      chk("overflow",    int'(overflow),    x.ovf,   x.cyc);
      chk("underflow",   int'(underflow),   x.unf,   x.cyc);
      chk("drop_cnt",    int'(drop_cnt),    x.drops, x.cyc);
    end
  end

  initial begin
    int wait_cyc;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    m_ovf   = 0;
    m_unf   = 0;
    m_drops = 0;
    reset_n = 1'b0;
    flush   = 1'b0;
    enq     = 1'b0;
    deq     = 1'b0;
    in_tag  = '0;
    @(negedge clk);

    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 8'h99);

    // fill to full
    step(1, 0, 1, 0, 8'h11);
    step(1, 0, 1, 0, 8'h22);
    step(1, 0, 1, 0, 8'h33);
    step(1, 0, 1, 0, 8'h44);

    // drops, past saturation
    for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 8'h55);

    // full with enq+deq, then drain
    step(1, 0, 1, 1, 8'h66);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);

    // wrap with streaming, then underflow
    step(1, 0, 1, 0, 8'hA0);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 1, 8'hB0 + i);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);

    // empty with enq+deq
    step(1, 0, 1, 1, 8'h7A);

    // flush priority at count 3
    step(1, 0, 1, 0, 8'h7B);
    step(1, 0, 1, 0, 8'h7C);
    step(1, 1, 1, 0, 8'h01);
    step(1, 0, 0, 0, 0);

    // reset priority at count 2
    step(1, 0, 1, 0, 8'hC1);
    step(1, 0, 1, 0, 8'hC2);
    step(0, 0, 1, 0, 8'hC3);
    step(1, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      int p;
      bit r;
      bit f;
      p = int'($urandom_range(0, 199));
      r = (p != 0);
      f = (p >= 1 && p <= 3);
      step(r, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 255)));
    end

    reset_n = 1'b1;
    flush   = 1'b0;
    enq     = 1'b0;
    deq     = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 5) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fire_tag_fifo.md
# fire_tag_fifo

Parametrised spike-event FIFO between the neuron update pipeline and the synapse fan-out stage. It buffers the tags of neurons that fired in the current timestep. This generation widens the tag from 1 bit to TAG_W bits and makes depth configurable. It adds occupancy/almost-full reporting, a timestep flush, and drop/underflow accounting, so that spike loss under back-pressure is observable instead of silent.

## Interface
- TAG_W, 8: width of a neuron tag (neuron index).
- DEPTH, 16: number of entries; power of two, ≥ 2.
- AFULL_LVL, DEPTH-2: almost_full asserts when count ≥ AFULL_LVL; range 1..DEPTH.
- DROP_W, 8: width of the saturating drop counter.

- clk  in  1  rising-edge clock; all state changes on this edge.
- reset_n  in  1  synchronous, active-low reset.
- enq  in  1  push in_tag this cycle.
- deq  in  1  pop head entry this cycle.
- flush  in  1  discard all contents at end of timestep.
- in_tag  in  TAG_W  tag to push.
- out_tag  out  TAG_W  head entry (first-word fall-through); 0 when empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: an enq was dropped.
- underflow  out  1  sticky: a deq hit an empty FIFO.
- drop_cnt  out  DROP_W  number of dropped enqs, saturating at 2^DROP_W-1.

## Operation
- Storage: circular buffer. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked explicitly.
- Priority on each edge: reset_n low > flush > enq/deq.
- Reset: pointers, count, overflow, underflow, drop_cnt all 0. empty=1, full=0, almost_full=0, out_tag=0. Memory contents are don't-care.
- flush: pointers, count, sticky flags and drop_cnt are cleared. enq/deq in the same cycle are ignored; in_tag is not stored.
- Accept rules, evaluated on pre-edge state:
  - enq accepted iff !full, or (full && deq). A full FIFO with simultaneous deq accepts both; count is unchanged.
  - deq accepted iff !empty. Empty with simultaneous enq: the enq is accepted, the deq is ignored (underflow set), and count becomes 1.
  - enq rejected (full, no deq): tag discarded, overflow←1, drop_cnt+1 unless saturated.
  - deq rejected (empty): no state change except underflow←1.
- Accepted enq writes mem[wr_ptr] and advances wr_ptr. Accepted deq advances rd_ptr.
- count next = count + enq_acc − deq_acc.
- full, empty and almost_full are decoded from the registered count, so they are glitch-free.
- out_tag = empty ? 0 : mem[rd_ptr] (combinational read).

## Timing
- Write-to-read latency is 1 cycle. A tag enqueued at edge N appears on out_tag, with empty=0, right after edge N.
- The consumer samples out_tag while asserting deq. The next entry is presented after that edge.
- All status outputs update on the same edge as the operation that caused them. There is no lookahead.
- Sustained throughput: one enq and one deq per cycle at any occupancy, including full.
- Pointer wrap: DEPTH consecutive accepted enqs from empty return wr_ptr to 0 and set full, with no extra cycle.
- Reset or flush asserted mid-stream: all outputs take their reset values right after that edge. Traffic in that cycle is lost without being counted.

## Structure
- Package fire_pkg: default TAG_W, a tag_t typedef, and a function computing count width from DEPTH. It is shared with the neuron pipeline and the fan-out stage.
- Sub-module fire_fifo_mem: DEPTH×TAG_W register file with one synchronous write port and one asynchronous read port, and no reset.
- The top level holds pointers, count, flags and drop counter.

## Test plan
- Reset then fill (TAG_W=8, DEPTH=4, AFULL_LVL=3): enq 0x11,0x22,0x33,0x44 → count 1,2,3,4; almost_full at count 3; full at 4; out_tag=0x11 throughout.
- Overflow on a full FIFO: enq 0x55 → contents unchanged, overflow=1, drop_cnt=1. Three more drops → drop_cnt=4. With DROP_W=2, drop_cnt saturates at 3.
- Simultaneous enq+deq when full: enq 0x66 with deq → out_tag 0x22, count stays 4, no drop. Drain four entries → 0x22,0x33,0x44,0x66, then empty=1 and out_tag=0.
- Wrap and underflow: 10 cycles of enq+deq from count 1 → FIFO order preserved across pointer wrap. Extra deq on empty → underflow=1, count 0.
- Empty with enq+deq: enq 0x7A with deq → count 1, out_tag 0x7A, underflow=1.
- Flush and reset priority: with count 3, flush plus enq 0x01 → count 0, empty, flags cleared, 0x01 not stored. With count 2, reset_n=0 plus enq → all outputs at reset values after the edge.
